// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: arms the BCD counter, waits, lights the stimulus and gates tick enables until React.
// Optional macro RANDOM_DELAY_EN replaces the fixed delay with an LFSR-derived delay latched at ARM.
module reaction_timer_ctrl #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned DELAY_TICKS = 2000,
    parameter int unsigned MAX_TICKS   = 9999,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic Start,
    input  logic React,
    output logic CntClear,
    output logic CntEnable,
    output logic Light,
    output logic Foul,
    output logic Timeout,
    output logic Busy
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   MAX_LAST   = 16'(MAX_TICKS - 1);

    if (TICK_DIV < 2 || MAX_TICKS == 0 || MAX_TICKS > 9999 || LFSR_SEED == 16'h0000) begin : g_bad_params
        $error("reaction_timer_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_RUN,
        S_DONE,
        S_FOUL,
        S_TOUT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        start_q;
    logic        react_q;
    logic        start_p;
    logic        react_p;
    logic [PW-1:0] presc;
    logic        tick;
    logic [15:0] tick_cnt;
    logic [15:0] delay_last;

    assign start_p = Start & ~start_q;
    assign react_p = React & ~react_q;
    assign tick    = (presc == PRESC_LAST);

`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr;
    logic [11:0] delay_q;

    // Right-shifting Galois form; mask 0xB400 realises taps 16,14,13,11.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            lfsr    <= LFSR_SEED;
            delay_q <= '0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (state == S_ARM) begin
                delay_q <= 12'd1000 + {1'b0, lfsr[10:0]};
            end
        end
    end

    assign delay_last = {4'b0000, delay_q} - 16'd1;
`else
    assign delay_last = 16'(DELAY_TICKS - 1);
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            react_q <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= Start;
            react_q <= React;
        end
    end

    always_comb begin
        next_state = state;
        CntEnable  = 1'b0;
        case (state)
            S_IDLE: if (start_p) next_state = S_ARM;
            S_ARM:  next_state = S_WAIT;
            S_WAIT: begin
                if (react_p) begin
                    next_state = S_FOUL;
                end else if (tick && tick_cnt == delay_last) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                // A press in the same cycle as a tick wins: that tick is not counted.
                if (react_p) begin
                    next_state = S_DONE;
                end else begin
                    CntEnable = tick;
                    if (tick && tick_cnt == MAX_LAST) next_state = S_TOUT;
                end
            end
            S_DONE, S_FOUL, S_TOUT: if (start_p) next_state = S_ARM;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc    <= '0;
            tick_cnt <= '0;
        end else if (next_state != state) begin
            presc    <= '0;
            tick_cnt <= '0;
        end else if (state == S_WAIT || state == S_RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            CntClear <= 1'b0;
            Light    <= 1'b0;
            Foul     <= 1'b0;
            Timeout  <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            CntClear <= (next_state == S_ARM);
            Light    <= (next_state == S_RUN);
            Foul     <= (next_state == S_FOUL);
            Timeout  <= (next_state == S_TOUT);
            Busy     <= (next_state == S_ARM) || (next_state == S_WAIT) || (next_state == S_RUN);
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl using a cycle-arithmetic reference model
// (WAIT lasts DELAY*TICK_DIV cycles, enables = complete ticks before the React edge).
module tb_reaction_timer_ctrl;

    localparam int TD    = 4;
    localparam int DT    = 5;
    localparam int MT    = 20;
    localparam int WAITC = TD * DT;
    localparam int RUNC  = TD * MT;
    localparam int LOOPN = WAITC + RUNC + 6;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    logic Start  = 1'b0;
    logic React  = 1'b0;
    logic CntClear, CntEnable, Light, Foul, Timeout, Busy;

    int checks = 0;
    int errors = 0;

    reaction_timer_ctrl #(
        .TICK_DIV   (TD),
        .DELAY_TICKS(DT),
        .MAX_TICKS  (MT)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .React    (React),
        .CntClear (CntClear),
        .CntEnable(CntEnable),
        .Light    (Light),
        .Foul     (Foul),
        .Timeout  (Timeout),
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic arm(input string name);
        @(posedge Clock); #1 Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
        @(negedge Clock);
        checks++;
        if (CntClear !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_arm: CntClear=%b Busy=%b, required 1 1", name, CntClear, Busy);
        end
        checks++;
        if ({Light, Foul, Timeout, CntEnable} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_arm_flags: Light/Foul/Timeout/CntEnable=%b, required 0000", name,
                     {Light, Foul, Timeout, CntEnable});
        end
        @(posedge Clock); #1;
    endtask

    // react_at / start_at are cycle indices counted from the first WAIT cycle;
    // start_at = -1 means no extra Start pulse, -2 means a random one while busy.
    task automatic run_trial(input string name, input int react_at, input int start_at);
        int  end_c, exp_en, en, clr, first_light, busy_bad, exp_light, sa;
        bit  exp_foul, exp_tout;
        exp_foul = 1'b0;
        exp_tout = 1'b0;
        if (react_at < WAITC) begin
            exp_foul = 1'b1; exp_en = 0; end_c = react_at;
        end else if (react_at - WAITC < RUNC) begin
            exp_en = (react_at - WAITC) / TD; end_c = react_at;
        end else begin
            exp_tout = 1'b1; exp_en = MT; end_c = WAITC + RUNC - 1;
        end
        exp_light = exp_foul ? -1 : WAITC;
        sa = (start_at == -2) ? int'($urandom_range(0, end_c)) : start_at;

        arm(name);
        en = 0; clr = 0; first_light = -1; busy_bad = 0;
        for (int c = 0; c < LOOPN; c++) begin
            React = (c == react_at);
            Start = (c == sa);
            @(negedge Clock);
            if (CntEnable === 1'b1) en++;
            if (CntClear === 1'b1) clr++;
            if (Light === 1'b1 && first_light < 0) first_light = c;
            if (Busy !== (c <= end_c)) busy_bad++;
            if (c == react_at && react_at >= WAITC && react_at - WAITC < RUNC) begin
                checks++;
                if (CntEnable !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_enable_on_react: CntEnable=%b, required 0", name, CntEnable);
                end
            end
            @(posedge Clock); #1;
        end
        React = 1'b0;
        Start = 1'b0;

        checks++;
        if (en != exp_en) begin
            errors++;
            $display("FAIL %s_enables: got %0d pulses, required %0d", name, en, exp_en);
        end
        checks++;
        if (clr != 0) begin
            errors++;
            $display("FAIL %s_clear_len: %0d extra CntClear cycles, required 0", name, clr);
        end
        checks++;
        if (first_light != exp_light) begin
            errors++;
            $display("FAIL %s_light_rise: first Light cycle %0d, required %0d", name, first_light, exp_light);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s_busy: %0d cycles with wrong Busy, required 0", name, busy_bad);
        end
        checks++;
        if ({Light, Foul, Timeout, Busy} !== {1'b0, exp_foul, exp_tout, 1'b0}) begin
            errors++;
            $display("FAIL %s_final: Light/Foul/Timeout/Busy=%b, required %b", name,
                     {Light, Foul, Timeout, Busy}, {1'b0, exp_foul, exp_tout, 1'b0});
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        #12;
        checks++;
        if ({CntClear, CntEnable, Light, Foul, Timeout, Busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {CntClear, CntEnable, Light, Foul, Timeout, Busy});
        end
        @(negedge Clock); Resetn = 1'b1;
        @(posedge Clock); #1 React = 1'b1;
        @(posedge Clock); #1 React = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if ({CntClear, CntEnable, Light, Foul, Timeout, Busy} !== 6'b0) begin
            errors++;
            $display("FAIL idle_ignores_react: got %b, required 000000",
                     {CntClear, CntEnable, Light, Foul, Timeout, Busy});
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_held_inputs();
        int clr, en;
        @(posedge Clock); #1 React = 1'b1;
        @(posedge Clock); #1 Start = 1'b1;
        clr = 0; en = 0;
        repeat (WAITC + RUNC + 20) begin
            @(negedge Clock);
            if (CntClear === 1'b1) clr++;
            if (CntEnable === 1'b1) en++;
            @(posedge Clock); #1;
        end
        checks++;
        if (clr != 1) begin
            errors++;
            $display("FAIL held_clear_count: got %0d ARM cycles, required 1", clr);
        end
        checks++;
        if (en != MT) begin
            errors++;
            $display("FAIL held_enables: got %0d pulses, required %0d", en, MT);
        end
        checks++;
        if ({Light, Foul, Timeout, Busy} !== 4'b0010) begin
            errors++;
            $display("FAIL held_timeout: Light/Foul/Timeout/Busy=%b, required 0010",
                     {Light, Foul, Timeout, Busy});
        end
        Start = 1'b0;
        React = 1'b0;
        @(posedge Clock); #1 React = 1'b1;
        @(posedge Clock); #1 React = 1'b0;
        @(negedge Clock);
        checks++;
        if (Timeout !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL tout_ignores_react: Timeout=%b Busy=%b, required 1 0", Timeout, Busy);
        end
        arm("held_repress");
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        while (Light !== 1'b1 && n < 60) begin
            @(posedge Clock); #1;
            n++;
        end
        checks++;
        if (Light !== 1'b1) begin
            errors++;
            $display("FAIL midrun_light_wait: Light=%b after %0d cycles, required 1", Light, n);
        end
        repeat (6) @(posedge Clock);
        #3 Resetn = 1'b0;
        #1;
        checks++;
        if ({CntClear, CntEnable, Light, Foul, Timeout, Busy} !== 6'b0) begin
            errors++;
            $display("FAIL midrun_async_reset: got %b, required 000000",
                     {CntClear, CntEnable, Light, Foul, Timeout, Busy});
        end
        @(negedge Clock); Resetn = 1'b1;
        @(posedge Clock); #1 React = 1'b1;
        @(posedge Clock); #1 React = 1'b0;
        @(negedge Clock);
        checks++;
        if ({CntClear, Light, Busy} !== 3'b000) begin
            errors++;
            $display("FAIL midrun_idle: CntClear/Light/Busy=%b, required 000", {CntClear, Light, Busy});
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            run_trial("random", int'($urandom_range(0, WAITC + RUNC + 10)),
                      ($urandom_range(0, 1) == 1) ? -2 : -1);
        end
    endtask

    initial begin
        test_reset();
        run_trial("react_7_ticks", WAITC + 7 * TD, -1);
        run_trial("foul_tick2", 7, -1);
        run_trial("timeout", 1000, -1);
        run_trial("react_on_tick", WAITC + 7, -1);
        run_trial("react_first_run_cycle", WAITC, -1);
        run_trial("react_last_run_cycle", WAITC + RUNC - 1, -1);
        run_trial("start_ignored_wait", WAITC + 10, 5);
        test_random();
        test_held_inputs();
        test_reset_mid_run();
        run_trial("back_to_back", WAITC + 3 * TD + 1, -1);
        run_trial("back_to_back_foul", 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
